scr1_tcm_dport_ctrl: RTL



---
 rtl/scr1_tcm_dport_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scr1_tcm_dport_ctrl.sv
// TCM port-B requester: maps core dmem req/ack transactions onto a 1-cycle registered-read memory.
// Optional post-reset zero fill of the whole TCM under SCR1_TCM_ZERO_INIT_EN.
module scr1_tcm_dport_ctrl #(
  parameter int unsigned SCR1_WIDTH = 32,
  parameter int unsigned SCR1_SIZE  = 32'h00010000,
  parameter int unsigned AW         = $clog2(SCR1_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dmem_req,
  input  logic                  dmem_cmd,
  input  logic [1:0]            dmem_width,
  input  logic [AW-1:0]         dmem_addr,
  input  logic [SCR1_WIDTH-1:0] dmem_wdata,
  output logic                  dmem_req_ack,
  output logic [SCR1_WIDTH-1:0] dmem_rdata,
  output logic [1:0]            dmem_resp,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [3:0]            mem_web,
  output logic [AW-3:0]         mem_addr,
  output logic [SCR1_WIDTH-1:0] mem_wdata,
  input  logic [SCR1_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
`ifdef SCR1_TCM_ZERO_INIT_EN
    ST_INIT,
`endif
    ST_IDLE,
    ST_RESP
  } state_t;

  state_t state, state_next;

  logic                  req_illegal;
  logic                  accept;
  logic [3:0]            byte_en;
  logic                  resp_err;
  logic                  resp_cmd;
  logic [1:0]            resp_width;
  logic [1:0]            resp_addr;
  logic [SCR1_WIDTH-1:0] rdata_shift;

`ifdef SCR1_TCM_ZERO_INIT_EN
  logic [AW-3:0] init_cnt;
  assign dmem_req_ack = (state != ST_INIT);
`else
  assign dmem_req_ack = 1'b1;
`endif

  assign accept = dmem_req & dmem_req_ack;

  always_comb begin
    req_illegal = 1'b0;
    byte_en     = 4'b1111;
    case (dmem_width)
      2'b00: byte_en = 4'b0001 << dmem_addr[1:0];
      2'b01: begin
        byte_en     = 4'b0011 << dmem_addr[1:0];
        req_illegal = dmem_addr[0];
      end
      2'b10: req_illegal = |dmem_addr[1:0];
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_web    = '0;
    mem_addr   = dmem_addr[AW-1:2];
    mem_wdata  = dmem_wdata << {dmem_addr[1:0], 3'b000};
    case (state)
`ifdef SCR1_TCM_ZERO_INIT_EN
      ST_INIT: begin
        mem_wen   = 1'b1;
        mem_web   = '1;
        mem_wdata = '0;
        mem_addr  = init_cnt;
        if (init_cnt == '1) state_next = ST_IDLE;
      end
`endif
      default: begin
        state_next = accept ? ST_RESP : ST_IDLE;
        if (accept && !req_illegal) begin
          mem_ren = ~dmem_cmd;
          mem_wen = dmem_cmd;
          mem_web = dmem_cmd ? byte_en : 4'b0000;
        end
      end
    endcase
    // Keep the memory quiet while reset is held, whatever the inputs do.
    if (!rst_n) begin
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      mem_web = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef SCR1_TCM_ZERO_INIT_EN
      state    <= ST_INIT;
      init_cnt <= '0;
`else
      state    <= ST_IDLE;
`endif
      resp_err   <= 1'b0;
      resp_cmd   <= 1'b0;
      resp_width <= 2'b00;
      resp_addr  <= 2'b00;
    end else begin
      state <= state_next;
`ifdef SCR1_TCM_ZERO_INIT_EN
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
`endif
      if (accept) begin
        resp_err   <= req_illegal;
        resp_cmd   <= dmem_cmd;
        resp_width <= dmem_width;
        resp_addr  <= dmem_addr[1:0];
      end
    end
  end

  assign dmem_resp   = (state == ST_RESP) ? (resp_err ? 2'b10 : 2'b01) : 2'b00;
  assign rdata_shift = mem_rdata >> {resp_addr, 3'b000};

  always_comb begin
    dmem_rdata = '0;
    if (state == ST_RESP && !resp_err && !resp_cmd) begin
      case (resp_width)
        2'b00:   dmem_rdata = {{(SCR1_WIDTH-8){1'b0}}, rdata_shift[7:0]};
        2'b01:   dmem_rdata = {{(SCR1_WIDTH-16){1'b0}}, rdata_shift[15:0]};
        default: dmem_rdata = rdata_shift;
      endcase
    end
  end

endmodule
